// File: rtl/con3_pkg.sv
// con3_pkg: shared widths, defaults and helpers for the CON3 servo generator
package con3_pkg;
    localparam int ANGLE_W        = 8;
    localparam int STEPS_PER_SLOT = 256;
    localparam int CLK_DIV_DEF    = 391;

    // One spare code is kept so out-of-range channel indices can be expressed and discarded
    function automatic int ch_idx_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/con3_timebase.sv
// con3_timebase: clock-enable prescaler plus step and slot counters for the servo frame
module con3_timebase
    import con3_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int FRAME_SLOTS = 20,
    parameter int SW          = cnt_w(FRAME_SLOTS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               commit,
    output logic [ANGLE_W-1:0] step,
    output logic [SW-1:0]      slot
);
    localparam int DW = cnt_w(CLK_DIV);

    logic [DW-1:0] div;
    logic          tick;

    assign tick   = (div == DW'(CLK_DIV - 1));
    assign commit = en && (div == '0) && (step == '0) && (slot == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= '0;
            step <= '0;
            slot <= '0;
        end else if (!en) begin
            div  <= '0;
            step <= '0;
            slot <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                step <= step + 1'b1;
                if (step == '1)
                    slot <= (slot == SW'(FRAME_SLOTS - 1)) ? '0 : slot + 1'b1;
            end
        end
    end
endmodule

// File: rtl/con3_multi.sv
// con3_multi: multi-channel servo pulse generator with frame-boundary double-buffered angles
module con3_multi
    import con3_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int BASE_SLOTS  = 1,
    parameter int FRAME_SLOTS = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [CH_NUM-1:0]             ch_en,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ch_idx_w(CH_NUM)-1:0]   wr_ch,
    input  logic [ANGLE_W-1:0]            wr_angle,
    output logic [CH_NUM-1:0]             servo,
    output logic                          frame_start
);
    localparam int CH_W = ch_idx_w(CH_NUM);
    localparam int SW   = cnt_w(FRAME_SLOTS);

    logic                 commit;
    logic [ANGLE_W-1:0]   step;
    logic [SW-1:0]        slot;
    logic [ANGLE_W-1:0]   shadow [CH_NUM];
    logic [ANGLE_W-1:0]   angle  [CH_NUM];
    logic [CH_NUM-1:0]    act_en, en_eff, pulse;

    con3_timebase #(.CLK_DIV(CLK_DIV), .FRAME_SLOTS(FRAME_SLOTS), .SW(SW)) u_tb (
        .clk(clk), .rst_n(rst_n), .en(en), .commit(commit), .step(step), .slot(slot)
    );

    assign wr_ready = ~commit | ~rst_n;
    // The commit cycle already drives the first pulse edge, so it must see the values being loaded
    assign en_eff   = commit ? ch_en : act_en;

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        logic [ANGLE_W-1:0] a;
        assign a        = commit ? shadow[n] : angle[n];
        assign pulse[n] = en_eff[n] && ((slot < SW'(BASE_SLOTS)) ||
                                        ((slot == SW'(BASE_SLOTS)) && (step < a)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            servo       <= '0;
            frame_start <= 1'b0;
            act_en      <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                shadow[i] <= '0;
                angle[i]  <= '0;
            end
        end else begin
            frame_start <= commit;
            servo       <= en ? pulse : '0;
            if (commit) begin
                act_en <= ch_en;
                for (int i = 0; i < CH_NUM; i++)
                    angle[i] <= shadow[i];
            end
            for (int i = 0; i < CH_NUM; i++)
                if (wr_valid && wr_ready && wr_ch == CH_W'(i))
                    shadow[i] <= wr_angle;
        end
    end
endmodule
